// File: rtl/memarb_pkg.sv
// Shared constants for the instruction/data memory port arbiter.
package memarb_pkg;

    localparam int unsigned MEMARB_DEF_AW       = 32;
    localparam int unsigned MEMARB_DEF_DW       = 32;
    localparam int unsigned MEMARB_DEF_MAX_WAIT = 15;
    localparam int unsigned MEMARB_CNT_W        = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IF_BUSY = 2'd1;
    localparam logic [1:0] ST_DM_BUSY = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = ST_IDLE,
        StIfBusy = ST_IF_BUSY,
        StDmBusy = ST_DM_BUSY
    } memarb_state_e;

endpackage

// File: rtl/memarb_wait_cnt.sv
// Watchdog counter for a busy memory transfer; expire fires on the cycle whose
// stalled edge would bring the count up to MAX_WAIT.
module memarb_wait_cnt
    import memarb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MEMARB_DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [MEMARB_CNT_W-1:0] Limit = MEMARB_CNT_W'(MAX_WAIT - 1);

    logic [MEMARB_CNT_W-1:0] cnt;

    assign expire = inc && (cnt == Limit);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + MEMARB_CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one shared memory, data port first.
// Optional watchdog abort is enabled by defining MEMARB_TIMEOUT_EN.
module mem_port_arbiter
    import memarb_pkg::*;
#(
    parameter int unsigned AW       = MEMARB_DEF_AW,
    parameter int unsigned DW       = MEMARB_DEF_DW,
    parameter int unsigned MAX_WAIT = MEMARB_DEF_MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_if,
    output logic          stall_dm,
    output logic          err
);

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("mem_port_arbiter: MAX_WAIT must be in 1..255");
    end

    memarb_state_e state;
    logic          dm_go;
    logic          if_go;
    logic          expire;

    // A request whose ack is showing this cycle is the one just served.
    assign dm_go    = dm_req && !dm_ack;
    assign if_go    = if_req && !if_ack;
    assign stall_dm = dm_req & ~dm_ack;
    assign stall_if = (if_req & ~if_ack) | stall_dm;

`ifdef MEMARB_TIMEOUT_EN
    logic grant;
    logic inc;
    logic err_q;

    assign grant = (state == StIdle) && (dm_go || if_go);
    assign inc   = (state != StIdle) && !mem_ready;

    memarb_wait_cnt #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (grant),
        .inc   (inc),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= expire;
        end
    end

    assign err = err_q;
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                StIdle: begin
                    if (dm_go) begin
                        state     <= StDmBusy;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (if_go) begin
                        state     <= StIfBusy;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                StIfBusy: begin
                    if (mem_ready || expire) begin
                        state    <= StIdle;
                        mem_req  <= 1'b0;
                        if_ack   <= 1'b1;
                        if_rdata <= mem_ready ? mem_rdata : '1;
                    end
                end
                StDmBusy: begin
                    if (mem_ready || expire) begin
                        state   <= StIdle;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        dm_ack  <= 1'b1;
                        if (!mem_we) begin
                            dm_rdata <= mem_ready ? mem_rdata : '1;
                        end
                    end
                end
                default: begin
                    state   <= StIdle;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized masters, checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned TB_MAX_WAIT = 4;
`ifdef MEMARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_dm;
    logic        err;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    mem_port_arbiter #(
        .AW      (32),
        .DW      (32),
        .MAX_WAIT(TB_MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .stall_if (stall_if),
        .stall_dm (stall_dm),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding transfer record plus the
    // visible ack/err pulses and the last data returned on each port.
    bit          m_valid = 1'b0;
    logic        m_active;
    logic        m_is_dm;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int unsigned m_waited;
    logic        e_if_ack;
    logic        e_dm_ack;
    logic        e_err;
    logic [31:0] e_if_rdata;
    logic [31:0] e_dm_rdata;

    always @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b1;
            m_active   <= 1'b0;
            m_is_dm    <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_waited   <= 0;
            e_if_ack   <= 1'b0;
            e_dm_ack   <= 1'b0;
            e_err      <= 1'b0;
            e_if_rdata <= '0;
            e_dm_rdata <= '0;
        end else if (m_valid) begin
            e_if_ack <= 1'b0;
            e_dm_ack <= 1'b0;
            e_err    <= 1'b0;
            if (!m_active) begin
                if (dm_req && !e_dm_ack) begin
                    m_active <= 1'b1;
                    m_is_dm  <= 1'b1;
                    m_we     <= dm_we;
                    m_addr   <= dm_addr;
                    m_wdata  <= dm_wdata;
                    m_waited <= 0;
                end else if (if_req && !e_if_ack) begin
                    m_active <= 1'b1;
                    m_is_dm  <= 1'b0;
                    m_we     <= 1'b0;
                    m_addr   <= if_addr;
                    m_waited <= 0;
                end
            end else if (mem_ready || (TIMEOUT_ON && m_waited + 1 == TB_MAX_WAIT)) begin
                m_active <= 1'b0;
                e_err    <= !mem_ready;
                if (m_is_dm) begin
                    e_dm_ack <= 1'b1;
                    if (!m_we) e_dm_rdata <= mem_ready ? mem_rdata : 32'hFFFF_FFFF;
                end else begin
                    e_if_ack   <= 1'b1;
                    e_if_rdata <= mem_ready ? mem_rdata : 32'hFFFF_FFFF;
                end
            end else begin
                m_waited <= m_waited + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("mem_req", mem_req, m_active);
            if (m_active) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", mem_we, m_we);
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("if_ack", if_ack, e_if_ack);
            chk("dm_ack", dm_ack, e_dm_ack);
            chk("err", err, e_err);
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("dm_rdata", dm_rdata, e_dm_rdata);
            chk("stall_dm", stall_dm, dm_req & ~e_dm_ack);
            chk("stall_if", stall_if, (if_req & ~e_if_ack) | (dm_req & ~e_dm_ack));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    bit if_ack_seen = 1'b0;
    bit dm_ack_seen = 1'b0;
    bit slow        = 1'b0;

    initial begin
        rst = 1'b1;  if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_acks", {if_ack, dm_ack, err}, 0);

        // Fetch, minimum latency.
        cyc(); if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        @(negedge clk); chk("f_stall_if_c0", stall_if, 1); chk("f_mem_req_c0", mem_req, 0);
        cyc(); @(negedge clk);
        chk("f_mem_req_c1", mem_req, 1); chk("f_mem_addr_c1", mem_addr, 32'h10);
        chk("f_mem_we_c1", mem_we, 0);
        cyc(); @(negedge clk);
        chk("f_if_ack_c2", if_ack, 1); chk("f_if_rdata_c2", if_rdata, 32'hA5A5_A5A5);
        chk("f_stall_if_c2", stall_if, 0);
        cyc(); if_req = 1'b0; @(negedge clk);
        chk("f_if_ack_c3", if_ack, 0); chk("f_mem_req_c3", mem_req, 0);

        // Simultaneous fetch and load: data port wins.
        cyc(); if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        mem_rdata = 32'h1111_2222;
        @(negedge clk); chk("s_stall_dm_c0", stall_dm, 1); chk("s_stall_if_c0", stall_if, 1);
        cyc(); @(negedge clk);
        chk("s_mem_addr_c1", mem_addr, 32'h40); chk("s_mem_we_c1", mem_we, 0);
        chk("s_stall_if_c1", stall_if, 1);
        cyc(); mem_rdata = 32'h3333_4444; @(negedge clk);
        chk("s_dm_ack_c2", dm_ack, 1); chk("s_dm_rdata_c2", dm_rdata, 32'h1111_2222);
        chk("s_mem_req_c2", mem_req, 0); chk("s_stall_if_c2", stall_if, 1);
        cyc(); dm_req = 1'b0; @(negedge clk);
        chk("s_mem_req_c3", mem_req, 1); chk("s_mem_addr_c3", mem_addr, 32'h20);
        cyc(); @(negedge clk);
        chk("s_if_ack_c4", if_ack, 1); chk("s_if_rdata_c4", if_rdata, 32'h3333_4444);
        cyc(); if_req = 1'b0; @(negedge clk);

        // Store with three wait cycles.
        cyc(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h8; dm_wdata = 32'h1234;
        mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 4) mem_ready = 1'b1;
            @(negedge clk);
            chk("st_mem_we", mem_we, 1); chk("st_mem_wdata", mem_wdata, 32'h1234);
            chk("st_mem_addr", mem_addr, 32'h8); chk("st_dm_ack_early", dm_ack, 0);
        end
        cyc(); @(negedge clk);
        chk("st_dm_ack_c5", dm_ack, 1); chk("st_dm_rdata", dm_rdata, 32'h1111_2222);
        cyc(); dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0; @(negedge clk);
        chk("st_dm_ack_c6", dm_ack, 0);

        // Reset in the middle of a fetch.
        cyc(); if_req = 1'b1; if_addr = 32'h30; @(negedge clk);
        cyc(); @(negedge clk); chk("r_mem_req_c1", mem_req, 1);
        cyc(); rst = 1'b1; @(negedge clk); chk("r_mem_req_c2", mem_req, 1);
        cyc(); rst = 1'b0; if_req = 1'b0; @(negedge clk);
        chk("r_mem_req", mem_req, 0); chk("r_mem_we", mem_we, 0);
        chk("r_mem_addr", mem_addr, 0); chk("r_mem_wdata", mem_wdata, 0);
        chk("r_if_rdata", if_rdata, 0); chk("r_dm_rdata", dm_rdata, 0);
        chk("r_acks", {if_ack, dm_ack, err}, 0);
        cyc(); @(negedge clk); chk("r_no_if_ack", if_ack, 0);

        // Memory never ready.
        cyc(); if_req = 1'b1; if_addr = 32'h50; mem_ready = 1'b0; @(negedge clk);
`ifdef MEMARB_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            cyc(); @(negedge clk);
            chk("t_err_early", err, 0); chk("t_mem_req_busy", mem_req, 1);
        end
        cyc(); @(negedge clk);
        chk("t_err", err, 1); chk("t_if_ack", if_ack, 1);
        chk("t_if_rdata", if_rdata, 32'hFFFF_FFFF); chk("t_mem_req", mem_req, 0);
        cyc(); if_req = 1'b0; @(negedge clk);
        chk("t_err_after", err, 0); chk("t_if_ack_after", if_ack, 0);
`else
        for (int k = 1; k <= 30; k++) begin
            cyc(); @(negedge clk);
            chk("t_no_ack", if_ack, 0); chk("t_mem_req_held", mem_req, 1);
            chk("t_no_err", err, 0);
        end
        cyc(); rst = 1'b1; if_req = 1'b0;
        cyc(); rst = 1'b0;
`endif

        // Randomized masters and memory.
        for (int c = 0; c < 3000; c++) begin
            cyc();
            rst = ($urandom_range(249) == 0);
            if (c % 400 == 0) slow = ~slow;
            mem_ready = slow ? ($urandom_range(9) == 0) : ($urandom_range(9) < 6);
            mem_rdata = $urandom;
            if (if_req) begin
                if (if_ack_seen) begin
                    if_req = 1'b0; if_ack_seen = 1'b0;
                end else if (e_if_ack) begin
                    if_ack_seen = 1'b1;
                end else if (!(m_active && !m_is_dm) && $urandom_range(15) == 0) begin
                    if_req = 1'b0;
                end
            end else if ($urandom_range(2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (dm_req) begin
                if (dm_ack_seen) begin
                    dm_req = 1'b0; dm_ack_seen = 1'b0;
                end else if (e_dm_ack) begin
                    dm_ack_seen = 1'b1;
                end else if (!(m_active && m_is_dm) && $urandom_range(15) == 0) begin
                    dm_req = 1'b0;
                end
            end else if ($urandom_range(2) == 0) begin
                dm_req = 1'b1; dm_we = $urandom_range(1) == 1;
                dm_addr = $urandom; dm_wdata = $urandom;
            end
        end
        cyc(); rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
